// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 opcode, branch funct3 and forwarding-select encodings.
package rv32_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_RS1  = 2'd1;
  localparam logic [1:0] FWD_RS2  = 2'd2;
  localparam logic [1:0] FWD_BOTH = 2'd3;
endpackage

// File: rtl/branch_predict_unit_cmp.sv
// branch_cmp: evaluates the six RV32 branch conditions; flags funct3 010/011 as illegal.
module branch_cmp
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o,
  output logic            legal_o
);
  always_comb begin
    taken_o = 1'b0;
    legal_o = 1'b1;
    case (funct3_i)
      F3_BEQ:  taken_o = a_i == b_i;
      F3_BNE:  taken_o = a_i != b_i;
      F3_BLT:  taken_o = $signed(a_i) < $signed(b_i);
      F3_BGE:  taken_o = $signed(a_i) >= $signed(b_i);
      F3_BLTU: taken_o = a_i < b_i;
      F3_BGEU: taken_o = a_i >= b_i;
      default: legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BHT + target buffer looked up in IF, resolved in EX,
// with single-pulse redirect/flush guarded by a registered shadow-kill.
module branch_predict_unit
  import rv32_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [XLEN-1:0]  if_pred_target,
  input  logic             ex_valid,
  input  logic [31:0]      ex_instr,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  alu_fb,
  input  logic [1:0]       fwd_sel,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flushF,
  output logic             flushD,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int IDXW = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WN  = CTR_WT - 1'b1;
  logic                valid_q [BHT_ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [BHT_ENTRIES];
  logic [XLEN-1:0]     tgt_q   [BHT_ENTRIES];
  logic                kill_q, kill_d;
  logic [CNT_W-1:0]    br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [CTR_BITS-1:0] ctr_d;
  logic [IDXW-1:0]     if_idx, ex_idx;
  logic [XLEN-1:0]     op_a, op_b;
  logic                taken, legal, is_br, upd, mispredict;
  logic                unused_bits;
  assign if_idx = if_pc[IDXW+1:2];
  assign ex_idx = ex_pc[IDXW+1:2];
  assign op_a   = (fwd_sel == FWD_RS1 || fwd_sel == FWD_BOTH) ? alu_fb : rs1;
  assign op_b   = (fwd_sel == FWD_RS2 || fwd_sel == FWD_BOTH) ? alu_fb : rs2;
  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a_i      (op_a),
    .b_i      (op_b),
    .funct3_i (ex_instr[14:12]),
    .taken_o  (taken),
    .legal_o  (legal)
  );
  // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
  always_comb begin
    if_pred_taken  = !rst && valid_q[if_idx] && ctr_q[if_idx][CTR_BITS-1];
    if_pred_target = (!rst && valid_q[if_idx]) ? tgt_q[if_idx] : '0;
    is_br          = !rst && ex_valid && !kill_q && ex_instr[6:0] == OPC_BRANCH;
    upd            = is_br && legal;
    mispredict     = taken ? (!ex_pred_taken || ex_pred_target != ex_target) : ex_pred_taken;
    redirect       = upd && mispredict;
    redirect_pc    = !redirect ? '0 : taken ? ex_target : ex_pc + XLEN'(4);
    ctr_d          = !valid_q[ex_idx] ? (taken ? CTR_WT : CTR_WN)
                   : taken ? (ctr_q[ex_idx] == CTR_MAX ? CTR_MAX : ctr_q[ex_idx] + 1'b1)
                   : (ctr_q[ex_idx] == '0 ? '0 : ctr_q[ex_idx] - 1'b1);
    kill_d         = redirect;
    br_cnt_d       = (upd && br_cnt_q != '1) ? br_cnt_q + 1'b1 : br_cnt_q;
    miss_cnt_d     = (redirect && miss_cnt_q != '1) ? miss_cnt_q + 1'b1 : miss_cnt_q;
  end
  assign flushF      = redirect;
  assign flushD      = redirect;
  assign br_count    = br_cnt_q;
  assign miss_count  = miss_cnt_q;
  assign unused_bits = ^{if_pc[XLEN-1:IDXW+2], if_pc[1:0], ex_instr[31:15], ex_instr[11:7]};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
      kill_q     <= 1'b0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (upd) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= ctr_d;
        if (taken) tgt_q[ex_idx] <= ex_target;
      end
      kill_q     <= kill_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: vector table, directed corner sequences and random stimulus
// checked against a behavioural predictor model.
module tb_branch_predict_unit;
  localparam int NE   = 64;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;
  logic          clk, rst;
  logic [31:0]   if_pc, ex_instr, ex_pc, ex_target, ex_pred_target, rs1, rs2, alu_fb;
  logic [31:0]   if_pred_target, redirect_pc;
  logic          if_pred_taken, ex_valid, ex_pred_taken, redirect, flushF, flushD;
  logic [1:0]    fwd_sel;
  logic [CW-1:0] br_count, miss_count;
  int errors = 0;
  int checks = 0;
  bit          m_valid [NE];
  int          m_ctr   [NE];
  logic [31:0] m_tgt   [NE];
  bit          m_kill;
  int          m_br, m_miss;
  bit          s_redirect, s_pt;
  logic [31:0] s_rpc, s_ptg;
  int          s_br, s_miss;
  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(NE), .CTR_BITS(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .rs1(rs1), .rs2(rs2), .alu_fb(alu_fb),
    .fwd_sel(fwd_sel), .redirect(redirect), .redirect_pc(redirect_pc),
    .flushF(flushF), .flushD(flushD), .br_count(br_count), .miss_count(miss_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int idx(input logic [31:0] pc);
    return int'((pc / 4) % NE);
  endfunction
  function automatic bit resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 output bit lg);
    lg = 1;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: begin lg = 0; return 0; end
    endcase
  endfunction
  task automatic reset_model();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0; m_ctr[i] = 0; m_tgt[i] = 0;
    end
    m_kill = 0; m_br = 0; m_miss = 0;
  endtask
  // One clock of model prediction, comparison just before the edge, then model update.
  task automatic cycle(input string tag);
    int li, ei;
    bit lg, tk, br, mis, ept;
    logic [31:0] a, b, eptg, erpc;
    li   = idx(if_pc);
    ei   = idx(ex_pc);
    ept  = !rst && m_valid[li] && m_ctr[li] >= 2;
    eptg = (!rst && m_valid[li]) ? m_tgt[li] : 32'h0;
    a    = (fwd_sel == 2'd1 || fwd_sel == 2'd3) ? alu_fb : rs1;
    b    = (fwd_sel == 2'd2 || fwd_sel == 2'd3) ? alu_fb : rs2;
    tk   = resolve(ex_instr[14:12], a, b, lg);
    br   = !rst && ex_valid && !m_kill && ex_instr[6:0] == 7'h63 && lg;
    mis  = br && (tk != ex_pred_taken || (tk && ex_pred_target != ex_target));
    erpc = !mis ? 32'h0 : tk ? ex_target : ex_pc + 32'd4;
    #3;
    s_redirect = redirect; s_rpc = redirect_pc; s_pt = if_pred_taken; s_ptg = if_pred_target;
    s_br = int'(br_count); s_miss = int'(miss_count);
    chk({tag, ".pred_taken"}, if_pred_taken, ept);
    chk({tag, ".pred_target"}, if_pred_target, eptg);
    chk({tag, ".redirect"}, redirect, mis);
    chk({tag, ".redirect_pc"}, redirect_pc, erpc);
    chk({tag, ".flushF"}, flushF, mis);
    chk({tag, ".flushD"}, flushD, mis);
    chk({tag, ".br_count"}, br_count, 64'(m_br));
    chk({tag, ".miss_count"}, miss_count, 64'(m_miss));
    @(posedge clk);
    if (rst) reset_model();
    else begin
      m_kill = mis;
      if (br) begin
        m_ctr[ei]   = !m_valid[ei] ? (tk ? 2 : 1) : tk ? (m_ctr[ei] < 3 ? m_ctr[ei] + 1 : 3)
                    : (m_ctr[ei] > 0 ? m_ctr[ei] - 1 : 0);
        m_valid[ei] = 1;
        if (tk) m_tgt[ei] = ex_target;
        m_br = m_br < CMAX ? m_br + 1 : CMAX;
      end
      if (mis) m_miss = m_miss < CMAX ? m_miss + 1 : CMAX;
    end
    #1;
  endtask
  task automatic set_br(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] fb, input logic [1:0] fs,
                        input bit pt, input logic [31:0] ptg, input logic [31:0] tgt);
    ex_valid = 1; ex_instr = {17'h0, f3, 5'h0, 7'h63}; ex_pc = pc;
    rs1 = a; rs2 = b; alu_fb = fb; fwd_sel = fs;
    ex_pred_taken = pt; ex_pred_target = ptg; ex_target = tgt;
  endtask
  task automatic idle(input logic [31:0] lpc);
    ex_valid = 0; if_pc = lpc;
  endtask
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, fb;
    logic [1:0]  fs;
    bit          tk;
  } vec_t;
  vec_t vt [11];
  logic [31:0] pcs [6];
  logic [2:0]  f3s [7];
  int          k, miss0;
  logic [2:0]  f3;
  initial begin
    vt[0]  = '{3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 1'b1};
    vt[1]  = '{3'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 1'b0};
    vt[2]  = '{3'd5, 32'd7, 32'd7, 32'd0, 2'd0, 1'b1};
    vt[3]  = '{3'd7, 32'd7, 32'd7, 32'd0, 2'd0, 1'b1};
    vt[4]  = '{3'd0, 32'd9, 32'd3, 32'd9, 2'd2, 1'b1};
    vt[5]  = '{3'd0, 32'd9, 32'd3, 32'd9, 2'd0, 1'b0};
    vt[6]  = '{3'd1, 32'd9, 32'd3, 32'd0, 2'd0, 1'b1};
    vt[7]  = '{3'd5, 32'hFFFF_FFFB, 32'd2, 32'd0, 2'd0, 1'b0};
    vt[8]  = '{3'd7, 32'hFFFF_FFFB, 32'd2, 32'd0, 2'd0, 1'b1};
    vt[9]  = '{3'd4, 32'd100, 32'd0, 32'hFFFF_FFF8, 2'd1, 1'b1};
    vt[10] = '{3'd0, 32'd1, 32'd2, 32'd3, 2'd3, 1'b1};
    pcs = '{32'h1000, 32'h1004, 32'h1008, 32'h1100, 32'h1044, 32'h1200};
    f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
    rst = 1; if_pc = 32'h100; ex_valid = 0; ex_instr = 0; ex_pc = 0; ex_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0; rs1 = 0; rs2 = 0; alu_fb = 0; fwd_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    rst = 0;
    idle(32'h100); cycle("reset");
    chk("reset.lookup_taken", s_pt, 1'b0);
    chk("reset.lookup_target", s_ptg, 32'h0);
    set_br(32'h40, 3'd0, 32'd5, 32'd5, 32'd0, 2'd0, 0, 32'h0, 32'h80); if_pc = 32'h100;
    cycle("beq_first");
    chk("beq_first.redirect", s_redirect, 1'b1);
    chk("beq_first.redirect_pc", s_rpc, 32'h80);
    if_pc = 32'h40; cycle("beq_shadow");
    chk("beq_shadow.killed", s_redirect, 1'b0);
    chk("beq_shadow.lookup_taken", s_pt, 1'b1);
    chk("beq_shadow.lookup_target", s_ptg, 32'h80);
    for (int i = 0; i < 11; i++) begin
      set_br(32'h400 + 32'(i) * 4, vt[i].f3, vt[i].a, vt[i].b, vt[i].fb, vt[i].fs, 0, 32'h0,
             32'h800 + 32'(i) * 16);
      cycle("vec");
      chk("vec.redirect", s_redirect, vt[i].tk);
      chk("vec.redirect_pc", s_rpc, vt[i].tk ? 32'h800 + 32'(i) * 16 : 32'h0);
      idle(32'h400 + 32'(i) * 4); cycle("vec_idle");
    end
    set_br(32'h40, 3'd0, 32'd1, 32'd1, 32'd0, 2'd0, 1, 32'h80, 32'h90); if_pc = 32'h40;
    cycle("tgt_miss");
    chk("tgt_miss.redirect_pc", s_rpc, 32'h90);
    chk("tgt_miss.old_target", s_ptg, 32'h80);
    idle(32'h40); cycle("tgt_after");
    chk("tgt_after.new_target", s_ptg, 32'h90);
    set_br(32'h2C0, 3'd0, 32'd4, 32'd4, 32'd0, 2'd0, 0, 32'h0, 32'h300); cycle("sat_t1");
    idle(32'h2C0); cycle("sat_kill");
    for (int i = 0; i < 3; i++) begin
      set_br(32'h2C0, 3'd0, 32'd4, 32'd4, 32'd0, 2'd0, 1, 32'h300, 32'h300); if_pc = 32'h2C0;
      cycle("sat_tk");
      chk("sat_tk.no_redirect", s_redirect, 1'b0);
      chk("sat_tk.predict", s_pt, 1'b1);
    end
    miss0 = s_miss;
    set_br(32'h2C0, 3'd0, 32'd4, 32'd5, 32'd0, 2'd0, 1, 32'h300, 32'h300); cycle("sat_nt");
    chk("sat_nt.redirect_pc", s_rpc, 32'h2C4);
    idle(32'h2C0); cycle("sat_after");
    chk("sat_after.still_taken", s_pt, 1'b1);
    chk("sat_after.miss_inc", 64'(s_miss), 64'(miss0 + 1));
    set_br(32'h40, 3'd0, 32'd2, 32'd2, 32'd0, 2'd0, 0, 32'h0, 32'h80); rst = 1; if_pc = 32'h40;
    cycle("rst_redirect");
    chk("rst_redirect.redirect", s_redirect, 1'b0);
    rst = 0; idle(32'h40); cycle("rst_after");
    chk("rst_after.lookup_taken", s_pt, 1'b0);
    chk("rst_after.br_count", 64'(s_br), 64'd0);
    set_br(32'h40, 3'd2, 32'd2, 32'd2, 32'd0, 2'd0, 0, 32'h0, 32'h80); cycle("illegal");
    chk("illegal.redirect", s_redirect, 1'b0);
    idle(32'h40); cycle("illegal_after");
    chk("illegal_after.br_count", 64'(s_br), 64'd0);
    for (int n = 0; n < 500; n++) begin
      rst = $urandom_range(0, 99) == 0;
      ex_valid = $urandom_range(0, 9) != 0;
      f3 = f3s[$urandom_range(0, 6)];
      ex_instr = {17'($urandom), f3, 5'($urandom), ($urandom_range(0, 9) != 0) ? 7'h63 : 7'h33};
      k = $urandom_range(0, 5);
      ex_pc = pcs[k];
      if_pc = pcs[$urandom_range(0, 5)];
      rs1 = 32'($urandom_range(0, 3)) - 32'd2;
      rs2 = 32'($urandom_range(0, 3)) - 32'd2;
      alu_fb = 32'($urandom_range(0, 3)) - 32'd2;
      fwd_sel = 2'($urandom_range(0, 3));
      ex_target = 32'h2000 + 32'($urandom_range(0, 2)) * 32'h40;
      if ($urandom_range(0, 1) == 1) begin
        ex_pred_taken = m_valid[idx(ex_pc)] && m_ctr[idx(ex_pc)] >= 2;
        ex_pred_target = m_valid[idx(ex_pc)] ? m_tgt[idx(ex_pc)] : 32'h0;
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1));
        ex_pred_target = 32'h2000 + 32'($urandom_range(0, 2)) * 32'h40;
      end
      if (f3 == 3'd2) ex_pred_taken = 0;
      cycle("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
